// File: rtl/bsg_manycore_store_fence_ctrl.sv
// Credit-based sequencer for a tile's outbound remote stores: caps outstanding stores,
// counts acks back, and answers fence requests once everything is acknowledged or times out.
module bsg_manycore_store_fence_ctrl #(
  parameter int max_out_p    = 16,
  parameter int timeout_p    = 1024,
  parameter int data_width_p = 32,
  localparam int cntr_width_lp = $clog2(max_out_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     store_v_i,
  output logic                     store_yumi_o,
  output logic                     net_v_o,
  input  logic                     net_ready_i,
  input  logic                     ret_v_i,
  input  logic                     fence_v_i,
  output logic                     fence_yumi_o,
  output logic                     resp_v_o,
  output logic [data_width_p-1:0]  resp_data_o,
  input  logic                     resp_ready_i,
  output logic [cntr_width_lp-1:0] out_cnt_o,
  output logic                     timeout_o,
  output logic                     underflow_o
);

  localparam int wait_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam bit timeout_en_lp = (timeout_p != 0);
  localparam logic [wait_width_lp-1:0] wait_last_lp =
    timeout_en_lp ? wait_width_lp'(timeout_p - 1) : '0;
  localparam logic [cntr_width_lp-1:0] max_cnt_lp = cntr_width_lp'(max_out_p);

  localparam logic [1:0] state_idle = 2'd0;
  localparam logic [1:0] state_wait = 2'd1;
  localparam logic [1:0] state_resp = 2'd2;

  logic                     active_r;
  logic [1:0]               state_r, state_n;
  logic [cntr_width_lp-1:0] cnt_r, cnt_n;
  logic [wait_width_lp-1:0] wait_cnt_r, wait_cnt_n;
  logic [cntr_width_lp-1:0] resp_cnt_r, resp_cnt_n;
  logic                     timeout_r, timeout_n;
  logic                     underflow_r, underflow_n;
  logic                     inc, dec;

  // NOTE: reset asserts asynchronously but active_r rises on a clock edge, so every
  // combinational valid/yumi is gated by it and the block wakes up synchronously.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) active_r <= 1'b0;
    else          active_r <= 1'b1;
  end

  assign net_v_o      = active_r & store_v_i & (state_r == state_idle) & (cnt_r < max_cnt_lp);
  assign store_yumi_o = net_v_o & net_ready_i;
  // A same-cycle store wins so the fence is ordered behind it.
  assign fence_yumi_o = active_r & (state_r == state_idle) & fence_v_i & ~store_v_i;
  assign resp_v_o     = active_r & (state_r == state_resp);
  assign resp_data_o  = data_width_p'(resp_cnt_r);
  assign out_cnt_o    = cnt_r;
  assign timeout_o    = timeout_r;
  assign underflow_o  = underflow_r;

  assign inc = store_yumi_o;
  assign dec = active_r & ret_v_i;

  // NOTE: every always_comb output takes its hold value first, so no path infers a latch.
  always_comb begin
    cnt_n       = cnt_r;
    underflow_n = underflow_r;
    if (inc && !dec) begin
      cnt_n = cnt_r + cntr_width_lp'(1);
    end else if (!inc && dec) begin
      if (cnt_r != '0) cnt_n = cnt_r - cntr_width_lp'(1);
      else             underflow_n = 1'b1;
    end
  end

  // Completion looks at the post-ack count so a draining ack finishes the fence next cycle.
  always_comb begin
    state_n    = state_r;
    wait_cnt_n = wait_cnt_r;
    resp_cnt_n = resp_cnt_r;
    timeout_n  = timeout_r;
    case (state_r)
      state_idle: begin
        if (fence_yumi_o) begin
          state_n    = state_wait;
          wait_cnt_n = '0;
        end
      end
      state_wait: begin
        if (cnt_n == '0) begin
          resp_cnt_n = '0;
          state_n    = state_resp;
        end else if (timeout_en_lp && (wait_cnt_r == wait_last_lp)) begin
          timeout_n  = 1'b1;
          resp_cnt_n = cnt_r;
          state_n    = state_resp;
        end else if (wait_cnt_r != '1) begin
          wait_cnt_n = wait_cnt_r + wait_width_lp'(1);
        end
      end
      state_resp: begin
        if (resp_ready_i) state_n = state_idle;
      end
      default: state_n = state_idle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r     <= state_idle;
      cnt_r       <= '0;
      wait_cnt_r  <= '0;
      resp_cnt_r  <= '0;
      timeout_r   <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      wait_cnt_r  <= wait_cnt_n;
      resp_cnt_r  <= resp_cnt_n;
      timeout_r   <= timeout_n;
      underflow_r <= underflow_n;
    end
  end

endmodule
